// File: rtl/ddr_path_mode_sequencer.sv
// ddr_path_mode_sequencer
// Moves the controller AXI port between the RTL master path and the SystemC
// bridge path without cutting a transaction in half. The sequence is:
// wait for idle address channels, block new addresses, let outstanding bursts
// drain, flip mode_sel, hold the blocks through a settle window, then reopen.
// Outstanding-burst counters also back-pressure the address channels at the limit.
module ddr_path_mode_sequencer #(
    parameter int unsigned MAX_OUTST     = 16,
    parameter int unsigned SETTLE_CYC    = 4,
    parameter int unsigned DRAIN_TIMEOUT = 1024,
    parameter logic        MODE_RESET    = 1'b0,
    localparam int unsigned CNT_W        = $clog2(MAX_OUTST + 1)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             mode_req,
    input  logic             aw_valid,
    input  logic             aw_ready,
    input  logic             ar_valid,
    input  logic             ar_ready,
    input  logic             b_valid,
    input  logic             b_ready,
    input  logic             r_valid,
    input  logic             r_ready,
    input  logic             r_last,
    output logic             mode_sel,
    output logic             aw_block,
    output logic             ar_block,
    output logic             switch_busy,
    output logic [CNT_W-1:0] wr_outst,
    output logic [CNT_W-1:0] rd_outst,
    output logic             timeout_err,
    output logic             count_err
);

    localparam int unsigned TMR_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam int unsigned STL_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_QUIESCE,
        ST_DRAIN,
        ST_SWITCH,
        ST_SETTLE
    } state_t;

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic               tgt_q, tgt_d;
    logic               blk_q, blk_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [STL_W-1:0]   settle_q, settle_d;
    logic               tmo_q, tmo_d;
    logic               cerr_q, cerr_d;
    logic               clr_cnt;

    // Index 0 is the write direction, index 1 the read direction.
    logic [1:0]             cnt_inc;
    logic [1:0]             cnt_dec;
    logic [1:0]             cnt_ovf;
    logic [1:0][CNT_W-1:0]  cnt_val;

    assign cnt_inc = {ar_valid & ar_ready, aw_valid & aw_ready};
    assign cnt_dec = {r_valid & r_ready & r_last, b_valid & b_ready};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             ovf;

            // Saturating up/down counter; an attempt past either end flags ovf.
            always_comb begin
                cnt_d = cnt_q;
                ovf   = 1'b0;
                if (cnt_inc[gi] && !cnt_dec[gi]) begin
                    if (cnt_q == CNT_W'(MAX_OUTST)) begin
                        ovf = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (cnt_dec[gi] && !cnt_inc[gi]) begin
                    if (cnt_q == '0) begin
                        ovf = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                // A forced switch abandons whatever the controller still owes.
                if (clr_cnt) begin
                    cnt_d = '0;
                end
            end

            // Counter register.
            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_val[gi] = cnt_q;
            assign cnt_ovf[gi] = ovf;
        end
    endgenerate

    // Next-state logic for the switch sequence and its side registers.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        tgt_d    = tgt_q;
        timer_d  = '0;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        clr_cnt  = 1'b0;
        cerr_d   = cerr_q | (|cnt_ovf);
        case (state_q)
            ST_RUN: begin
                if (mode_req != mode_q) begin
                    tgt_d   = mode_req;
                    state_d = ST_QUIESCE;
                end
            end
            ST_QUIESCE: begin
                // Only block in a cycle with no address offered, so a valid is never withdrawn.
                if (!aw_valid && !ar_valid) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_val[0] == '0 && cnt_val[1] == '0) begin
                    state_d = ST_SWITCH;
                end else if (timer_q == TMR_W'(DRAIN_TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    clr_cnt = 1'b1;
                    state_d = ST_SWITCH;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_SWITCH: begin
                mode_d   = tgt_q;
                settle_d = STL_W'(SETTLE_CYC - 1);
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        // Block is registered and follows the state being entered, so it rises
        // on the DRAIN entry edge and falls on the RUN entry edge.
        blk_d = (state_d == ST_DRAIN) || (state_d == ST_SWITCH) || (state_d == ST_SETTLE);
    end

    // Sequencer state registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= ST_RUN;
            mode_q   <= MODE_RESET;
            tgt_q    <= MODE_RESET;
            blk_q    <= 1'b0;
            timer_q  <= '0;
            settle_q <= '0;
            tmo_q    <= 1'b0;
            cerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            tgt_q    <= tgt_d;
            blk_q    <= blk_d;
            timer_q  <= timer_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            cerr_q   <= cerr_d;
        end
    end

    assign mode_sel    = mode_q;
    assign wr_outst    = cnt_val[0];
    assign rd_outst    = cnt_val[1];
    assign aw_block    = blk_q | (cnt_val[0] == CNT_W'(MAX_OUTST));
    assign ar_block    = blk_q | (cnt_val[1] == CNT_W'(MAX_OUTST));
    assign switch_busy = (state_q != ST_RUN);
    assign timeout_err = tmo_q;
    assign count_err   = cerr_q;

endmodule

// File: tb/tb_ddr_path_mode_sequencer.sv
// Directed bench for ddr_path_mode_sequencer (default parameters).
module tb_ddr_path_mode_sequencer;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       mode_req = 1'b0;
    logic       aw_valid = 1'b0, aw_ready = 1'b0;
    logic       ar_valid = 1'b0, ar_ready = 1'b0;
    logic       b_valid = 1'b0, b_ready = 1'b0;
    logic       r_valid = 1'b0, r_ready = 1'b0, r_last = 1'b0;
    logic       mode_sel, aw_block, ar_block, switch_busy, timeout_err, count_err;
    logic [4:0] wr_outst, rd_outst;

    int total = 0;
    int bad   = 0;

    ddr_path_mode_sequencer dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .mode_req    (mode_req),
        .aw_valid    (aw_valid),
        .aw_ready    (aw_ready),
        .ar_valid    (ar_valid),
        .ar_ready    (ar_ready),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .r_valid     (r_valid),
        .r_ready     (r_ready),
        .r_last      (r_last),
        .mode_sel    (mode_sel),
        .aw_block    (aw_block),
        .ar_block    (ar_block),
        .switch_busy (switch_busy),
        .wr_outst    (wr_outst),
        .rd_outst    (rd_outst),
        .timeout_err (timeout_err),
        .count_err   (count_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Advance one cycle; outputs are then looked at 1 time unit after the edge.
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_inputs();
        aw_valid = 0; aw_ready = 0; ar_valid = 0; ar_ready = 0;
        b_valid = 0; b_ready = 0; r_valid = 0; r_ready = 0; r_last = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        mode_req = 0;
        sys_rst = 1;
        step();
        sys_rst = 0;
        step();
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (!switch_busy) begin
                ok = 1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        sys_rst = 1;
        step();
        step();
        total++;
        if ({mode_sel, aw_block, ar_block, switch_busy, timeout_err, count_err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000000",
                     {mode_sel, aw_block, ar_block, switch_busy, timeout_err, count_err});
        end
        total++;
        if ({wr_outst, rd_outst} !== 10'd0) begin
            bad++;
            $display("FAIL reset_counts wr=%0d rd=%0d want 0/0", wr_outst, rd_outst);
        end
        sys_rst = 0;
        step();
        $display("test_reset done");
    endtask

    task automatic test_idle_switch();
        bit ok;
        do_reset();
        mode_req = 1;                  // cycle 0
        step();                        // cycle 1
        total++;
        if ({aw_block, ar_block, switch_busy} !== 3'b001) begin
            bad++; $display("FAIL idle_c1 blk/busy got=%b want=001", {aw_block, ar_block, switch_busy});
        end
        step();                        // cycle 2
        total++;
        if ({aw_block, ar_block} !== 2'b11) begin
            bad++; $display("FAIL idle_c2 blocks got=%b want=11", {aw_block, ar_block});
        end
        step();                        // cycle 3
        total++;
        if (mode_sel !== 1'b0) begin
            bad++; $display("FAIL idle_c3 mode_sel got=%b want=0", mode_sel);
        end
        step();                        // cycle 4
        total++;
        if (mode_sel !== 1'b1) begin
            bad++; $display("FAIL idle_c4 mode_sel got=%b want=1", mode_sel);
        end
        mode_req = 0;                  // ignored until RUN
        repeat (3) step();             // cycle 7
        total++;
        if ({aw_block, ar_block, mode_sel} !== 3'b111) begin
            bad++; $display("FAIL idle_c7 blk/mode got=%b want=111", {aw_block, ar_block, mode_sel});
        end
        step();                        // cycle 8
        total++;
        if ({aw_block, ar_block, switch_busy, timeout_err, count_err} !== 5'b0) begin
            bad++; $display("FAIL idle_c8 blk/busy/err got=%b want=00000",
                            {aw_block, ar_block, switch_busy, timeout_err, count_err});
        end
        step();                        // cycle 9: RUN re-compared, new switch back
        total++;
        if (switch_busy !== 1'b1) begin
            bad++; $display("FAIL idle_reswitch busy got=%b want=1", switch_busy);
        end
        wait_idle(50, ok);
        total++;
        if (!ok || mode_sel !== 1'b0) begin
            bad++; $display("FAIL idle_return ok=%0b mode_sel=%b want ok=1 mode_sel=0", ok, mode_sel);
        end
        $display("test_idle_switch done");
    endtask

    task automatic test_drain();
        bit ok;
        do_reset();
        aw_valid = 1; aw_ready = 1;
        repeat (3) step();
        aw_valid = 0; aw_ready = 0; ar_valid = 1; ar_ready = 1;
        repeat (2) step();
        ar_valid = 0; ar_ready = 0;
        total++;
        if (wr_outst !== 5'd3 || rd_outst !== 5'd2) begin
            bad++; $display("FAIL drain_counts wr=%0d rd=%0d want 3/2", wr_outst, rd_outst);
        end
        mode_req = 1;
        repeat (7) step();             // in DRAIN, waiting
        total++;
        if ({mode_sel, aw_block, ar_block} !== 3'b011) begin
            bad++; $display("FAIL drain_wait mode/blk got=%b want=011", {mode_sel, aw_block, ar_block});
        end
        b_valid = 1; b_ready = 1;
        repeat (3) step();
        b_valid = 0; b_ready = 0;
        total++;
        if (wr_outst !== 5'd0 || mode_sel !== 1'b0 || switch_busy !== 1'b1) begin
            bad++; $display("FAIL drain_after_b wr=%0d mode=%b busy=%b want 0/0/1", wr_outst, mode_sel, switch_busy);
        end
        r_valid = 1; r_ready = 1; r_last = 1;
        repeat (2) step();             // last completion handshook in previous cycle
        r_valid = 0; r_ready = 0; r_last = 0;
        total++;
        if (rd_outst !== 5'd0 || mode_sel !== 1'b0) begin
            bad++; $display("FAIL drain_after_r rd=%0d mode=%b want 0/0", rd_outst, mode_sel);
        end
        step();                        // SWITCH cycle
        total++;
        if (mode_sel !== 1'b0) begin
            bad++; $display("FAIL drain_switch mode_sel got=%b want=0", mode_sel);
        end
        step();
        total++;
        if (mode_sel !== 1'b1) begin
            bad++; $display("FAIL drain_flip mode_sel got=%b want=1", mode_sel);
        end
        wait_idle(20, ok);
        total++;
        if (!ok || timeout_err !== 1'b0) begin
            bad++; $display("FAIL drain_end ok=%0b tmo=%b want 1/0", ok, timeout_err);
        end
        $display("test_drain done");
    endtask

    task automatic test_quiesce();
        bit ok;
        do_reset();
        aw_valid = 1; aw_ready = 0;
        mode_req = 1;
        repeat (6) step();
        total++;
        if ({aw_block, ar_block, switch_busy, mode_sel} !== 4'b0010) begin
            bad++; $display("FAIL quiesce_hold blk/busy/mode got=%b want=0010",
                            {aw_block, ar_block, switch_busy, mode_sel});
        end
        aw_valid = 0;
        step();
        total++;
        if ({aw_block, ar_block} !== 2'b11) begin
            bad++; $display("FAIL quiesce_release blocks got=%b want=11", {aw_block, ar_block});
        end
        wait_idle(20, ok);
        total++;
        if (!ok || mode_sel !== 1'b1) begin
            bad++; $display("FAIL quiesce_end ok=%0b mode_sel=%b want 1/1", ok, mode_sel);
        end
        $display("test_quiesce done");
    endtask

    task automatic test_limit();
        do_reset();
        aw_valid = 1; aw_ready = 1;
        repeat (16) step();
        total++;
        if (wr_outst !== 5'd16 || {aw_block, ar_block, count_err} !== 3'b100) begin
            bad++; $display("FAIL limit_full wr=%0d blk/err=%b want 16/100", wr_outst, {aw_block, ar_block, count_err});
        end
        b_valid = 1; b_ready = 1;      // AW and B together: unchanged, no error
        step();
        b_valid = 0; b_ready = 0;
        total++;
        if (wr_outst !== 5'd16 || count_err !== 1'b0) begin
            bad++; $display("FAIL limit_both wr=%0d err=%b want 16/0", wr_outst, count_err);
        end
        step();                        // 17th forced handshake
        aw_valid = 0; aw_ready = 0;
        total++;
        if (wr_outst !== 5'd16 || count_err !== 1'b1) begin
            bad++; $display("FAIL limit_overflow wr=%0d err=%b want 16/1", wr_outst, count_err);
        end
        do_reset();
        r_valid = 1; r_ready = 1; r_last = 1;
        step();
        clear_inputs();
        total++;
        if (rd_outst !== 5'd0 || count_err !== 1'b1) begin
            bad++; $display("FAIL limit_underflow rd=%0d err=%b want 0/1", rd_outst, count_err);
        end
        $display("test_limit done");
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        aw_valid = 1; aw_ready = 1;
        step();
        aw_valid = 0; aw_ready = 0;
        mode_req = 1;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (aw_block) begin
                ok = 1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++; $display("FAIL timeout_enter aw_block=%b want=1 within 10 cycles", aw_block);
        end
        repeat (1023) step();          // DRAIN timer now at DRAIN_TIMEOUT-1
        total++;
        if (timeout_err !== 1'b0 || wr_outst !== 5'd1 || mode_sel !== 1'b0) begin
            bad++; $display("FAIL timeout_pre tmo=%b wr=%0d mode=%b want 0/1/0", timeout_err, wr_outst, mode_sel);
        end
        step();
        total++;
        if (timeout_err !== 1'b1 || wr_outst !== 5'd0) begin
            bad++; $display("FAIL timeout_fire tmo=%b wr=%0d want 1/0", timeout_err, wr_outst);
        end
        step();
        total++;
        if (mode_sel !== 1'b1) begin
            bad++; $display("FAIL timeout_mode mode_sel=%b want=1", mode_sel);
        end
        wait_idle(20, ok);
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid_drain();
        bit ok;
        do_reset();
        aw_valid = 1; aw_ready = 1; ar_valid = 1; ar_ready = 1;
        step();
        clear_inputs();
        mode_req = 1;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (aw_block) begin
                ok = 1;
                break;
            end
        end
        repeat (3) step();
        total++;
        if (!ok || switch_busy !== 1'b1 || wr_outst !== 5'd1) begin
            bad++; $display("FAIL rstmid_pre ok=%0b busy=%b wr=%0d want 1/1/1", ok, switch_busy, wr_outst);
        end
        sys_rst = 1;
        #2;                            // asynchronous: no clock edge needed
        total++;
        if ({mode_sel, aw_block, ar_block, switch_busy, timeout_err} !== 5'b0 || {wr_outst, rd_outst} !== 10'd0) begin
            bad++; $display("FAIL rstmid_async flags=%b wr=%0d rd=%0d want 00000/0/0",
                            {mode_sel, aw_block, ar_block, switch_busy, timeout_err}, wr_outst, rd_outst);
        end
        mode_req = 0;
        step();
        sys_rst = 0;
        step();
        step();
        total++;
        if (switch_busy !== 1'b0 || mode_sel !== 1'b0) begin
            bad++; $display("FAIL rstmid_after busy=%b mode=%b want 0/0", switch_busy, mode_sel);
        end
        $display("test_reset_mid_drain done");
    endtask

    initial begin
        test_reset();
        test_idle_switch();
        test_drain();
        test_quiesce();
        test_limit();
        test_timeout();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
